// File: rtl/fc_ff_tx_feeder.sv
// Store-and-forward writer for the MAC ff_tx_* transmit FIFO interface.
// Sanitizes upstream frames, buffers whole frames, then bursts each one to the MAC gap-free.
module fc_ff_tx_feeder #(
  parameter int FIFO_ADDR = 10,
  parameter int MAX_WORDS = 537
) (
  input  logic        ff_tx_clk,
  input  logic        reset_ff_tx_clk,
  input  logic [31:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [1:0]  in_mod,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  cfg_class,
  input  logic [3:0]  cfg_end_code,
  input  logic [7:0]  cfg_gap,
  output logic [31:0] ff_tx_data,
  output logic        ff_tx_sop,
  output logic        ff_tx_eop,
  output logic [1:0]  ff_tx_mod,
  output logic        ff_tx_err,
  output logic        ff_tx_wren,
  output logic [3:0]  ff_tx_class,
  output logic [3:0]  ff_tx_end_code,
  input  logic        ff_tx_rdy,
  output logic [31:0] stat_frm_sent,
  output logic [15:0] stat_frm_trunc,
  output logic [15:0] stat_word_drop
);

  localparam int DEPTH = 2 ** FIFO_ADDR;
  localparam int PW    = FIFO_ADDR + 1;
  localparam int WCW   = $clog2(MAX_WORDS + 1);
  localparam logic [PW-1:0]  P_ONE   = PW'(1);
  localparam logic [PW-1:0]  P_DEPTH = PW'(DEPTH);
  localparam logic [WCW-1:0] W_ONE   = WCW'(1);
  localparam logic [WCW-1:0] W_MAX   = WCW'(MAX_WORDS);

  typedef enum logic [1:0] {IN_IDLE, IN_FRAME, IN_DISCARD} in_state_t;
  typedef enum logic [1:0] {EG_IDLE, EG_SEND, EG_GAP} eg_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  logic [36:0]    r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr, r_cnt, r_fcnt;
  logic           r_in_ready;
  in_state_t      r_in_st, w_in_nxt;
  logic [WCW-1:0] r_wcnt, w_wcnt_nxt;
  logic [15:0]    r_stat_trunc, r_stat_drop;

  eg_state_t      r_eg_st, w_eg_nxt;
  logic [7:0]     r_gap_cnt;
  logic [31:0]    r_tx_data;
  logic           r_tx_sop, r_tx_eop, r_tx_err, r_tx_wren;
  logic [1:0]     r_tx_mod;
  logic [3:0]     r_tx_class, r_tx_end_code;
  logic [31:0]    r_stat_sent;

  logic           w_accept, w_wr, w_drop, w_trunc;
  logic           w_wsop, w_weop, w_werr;
  logic [1:0]     w_wmod;
  logic [36:0]    w_wentry, w_head;
  logic           w_pop, w_xfer_eop;
  logic [PW-1:0]  w_cnt_nxt;

  assign w_accept = in_valid & r_in_ready;
  assign w_wentry = {in_data, w_wsop, w_weop, w_wmod, w_werr};
  assign w_head   = r_mem[r_rd_ptr[FIFO_ADDR-1:0]];
  assign w_cnt_nxt = r_cnt + (w_wr ? P_ONE : '0) - (w_pop ? P_ONE : '0);

  // Ingress: every accepted word is either stored or counted as dropped.
  always_comb begin
    w_in_nxt   = r_in_st;
    w_wr       = 1'b0;
    w_drop     = 1'b0;
    w_trunc    = 1'b0;
    w_wsop     = 1'b0;
    w_weop     = 1'b0;
    w_wmod     = 2'd0;
    w_werr     = 1'b0;
    w_wcnt_nxt = r_wcnt;
    if (w_accept) begin
      case (r_in_st)
        IN_IDLE: begin
          if (in_sop) begin
            w_wr       = 1'b1;
            w_wsop     = 1'b1;
            w_weop     = in_eop;
            w_wmod     = in_eop ? in_mod : 2'd0;
            w_wcnt_nxt = W_ONE;
            if (!in_eop) w_in_nxt = IN_FRAME;
          end else begin
            w_drop = 1'b1;
          end
        end
        IN_FRAME: begin
          w_wr       = 1'b1;
          w_wcnt_nxt = r_wcnt + W_ONE;
          if (in_eop) begin
            w_weop   = 1'b1;
            w_wmod   = in_mod;
            w_in_nxt = IN_IDLE;
          end else if (w_wcnt_nxt == W_MAX) begin
            w_weop   = 1'b1;
            w_werr   = 1'b1;
            w_trunc  = 1'b1;
            w_in_nxt = IN_DISCARD;
          end
        end
        IN_DISCARD: begin
          w_drop = 1'b1;
          if (in_eop) w_in_nxt = IN_IDLE;
        end
        default: w_in_nxt = IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge ff_tx_clk) begin
    if (w_wr && !reset_ff_tx_clk) r_mem[r_wr_ptr[FIFO_ADDR-1:0]] <= w_wentry;
  end

  always_ff @(posedge ff_tx_clk) begin
    if (reset_ff_tx_clk) begin
      r_in_st      <= IN_IDLE;
      r_wcnt       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_fcnt       <= '0;
      r_in_ready   <= 1'b0;
      r_stat_trunc <= '0;
      r_stat_drop  <= '0;
    end else begin
      r_in_st    <= w_in_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_cnt      <= w_cnt_nxt;
      r_in_ready <= (w_cnt_nxt < P_DEPTH);
      if (w_wr)    r_wr_ptr     <= r_wr_ptr + P_ONE;
      if (w_pop)   r_rd_ptr     <= r_rd_ptr + P_ONE;
      if (w_trunc) r_stat_trunc <= sat_inc16(r_stat_trunc);
      if (w_drop)  r_stat_drop  <= sat_inc16(r_stat_drop);
      case ({w_wr & w_weop, w_xfer_eop})
        2'b10:   r_fcnt <= r_fcnt + P_ONE;
        2'b01:   r_fcnt <= r_fcnt - P_ONE;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // Egress: a frame only starts once complete, so the next word is always present on transfer.
  always_comb begin
    w_eg_nxt   = r_eg_st;
    w_pop      = 1'b0;
    w_xfer_eop = 1'b0;
    case (r_eg_st)
      EG_IDLE: begin
        if (r_fcnt != '0) begin
          w_pop    = 1'b1;
          w_eg_nxt = EG_SEND;
        end
      end
      EG_SEND: begin
        if (ff_tx_rdy) begin
          if (r_tx_eop) begin
            w_xfer_eop = 1'b1;
            w_eg_nxt   = (cfg_gap != 8'd0) ? EG_GAP : EG_IDLE;
          end else begin
            w_pop = 1'b1;
          end
        end
      end
      EG_GAP: begin
        if (r_gap_cnt == 8'd0) w_eg_nxt = EG_IDLE;
      end
      default: w_eg_nxt = EG_IDLE;
    endcase
  end

  always_ff @(posedge ff_tx_clk) begin
    if (reset_ff_tx_clk) begin
      r_eg_st       <= EG_IDLE;
      r_gap_cnt     <= '0;
      r_tx_data     <= '0;
      r_tx_sop      <= 1'b0;
      r_tx_eop      <= 1'b0;
      r_tx_mod      <= '0;
      r_tx_err      <= 1'b0;
      r_tx_wren     <= 1'b0;
      r_tx_class    <= '0;
      r_tx_end_code <= '0;
      r_stat_sent   <= '0;
    end else begin
      r_eg_st   <= w_eg_nxt;
      r_tx_wren <= (w_eg_nxt == EG_SEND);
      if (w_pop) begin
        r_tx_data <= w_head[36:5];
        r_tx_sop  <= w_head[4];
        r_tx_eop  <= w_head[3];
        r_tx_mod  <= w_head[2:1];
        r_tx_err  <= w_head[0];
      end
      if (w_pop && r_eg_st == EG_IDLE) begin
        r_tx_class    <= cfg_class;
        r_tx_end_code <= cfg_end_code;
      end
      if (w_xfer_eop) begin
        r_gap_cnt   <= cfg_gap - 8'd1;
        r_stat_sent <= sat_inc32(r_stat_sent);
      end else if (r_eg_st == EG_GAP) begin
        r_gap_cnt <= r_gap_cnt - 8'd1;
      end
    end
  end

  assign in_ready       = r_in_ready;
  assign ff_tx_data     = r_tx_data;
  assign ff_tx_sop      = r_tx_sop;
  assign ff_tx_eop      = r_tx_eop;
  assign ff_tx_mod      = r_tx_mod;
  assign ff_tx_err      = r_tx_err;
  assign ff_tx_wren     = r_tx_wren;
  assign ff_tx_class    = r_tx_class;
  assign ff_tx_end_code = r_tx_end_code;
  assign stat_frm_sent  = r_stat_sent;
  assign stat_frm_trunc = r_stat_trunc;
  assign stat_word_drop = r_stat_drop;

endmodule

// File: tb/tb_fc_ff_tx_feeder.sv
// Bench for fc_ff_tx_feeder: frame table plus hand sequences, egress checked by a scoreboard queue.
module tb_fc_ff_tx_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_sop, in_eop, in_valid;
  logic [1:0]  in_mod;
  logic        in_ready;
  logic [3:0]  cfg_class, cfg_end_code;
  logic [7:0]  cfg_gap;
  logic [31:0] ff_tx_data;
  logic        ff_tx_sop, ff_tx_eop, ff_tx_err, ff_tx_wren, ff_tx_rdy;
  logic [1:0]  ff_tx_mod;
  logic [3:0]  ff_tx_class, ff_tx_end_code;
  logic [31:0] stat_frm_sent;
  logic [15:0] stat_frm_trunc, stat_word_drop;

  fc_ff_tx_feeder #(.FIFO_ADDR(10), .MAX_WORDS(537)) dut (
    .ff_tx_clk(clk), .reset_ff_tx_clk(rst),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_mod(in_mod),
    .in_valid(in_valid), .in_ready(in_ready),
    .cfg_class(cfg_class), .cfg_end_code(cfg_end_code), .cfg_gap(cfg_gap),
    .ff_tx_data(ff_tx_data), .ff_tx_sop(ff_tx_sop), .ff_tx_eop(ff_tx_eop),
    .ff_tx_mod(ff_tx_mod), .ff_tx_err(ff_tx_err), .ff_tx_wren(ff_tx_wren),
    .ff_tx_class(ff_tx_class), .ff_tx_end_code(ff_tx_end_code), .ff_tx_rdy(ff_tx_rdy),
    .stat_frm_sent(stat_frm_sent), .stat_frm_trunc(stat_frm_trunc),
    .stat_word_drop(stat_word_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
    logic        err;
    logic [3:0]  cls;
    logic [3:0]  ec;
  } exp_t;

  typedef struct {
    int         len;
    logic [1:0] mod;
    int         orphans;
    logic [3:0] cls;
    int         exp_out;
    logic [1:0] exp_mod;
    logic       exp_err;
    int         exp_drop;
    int         exp_trunc;
  } vec_t;

  exp_t q[$];
  vec_t tbl[6];
  int   n_cmp = 0, n_fail = 0;
  int   cyc = 0, xfer_cnt = 0;
  int   eop_acc_cyc = 0, sop_cyc = 0, eop_xfer_cyc = 0, gap_seen = 0;
  int   exp_sent = 0, exp_trunc = 0, exp_drop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int tag, input int i);
    return (32'(tag) << 20) | 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (in_valid && in_ready && in_eop) eop_acc_cyc = cyc;
      if (ff_tx_wren && ff_tx_rdy) begin
        xfer_cnt++;
        if (ff_tx_sop) begin
          gap_seen = cyc - eop_xfer_cyc - 1;
          sop_cyc  = cyc;
        end
        if (ff_tx_eop) eop_xfer_cyc = cyc;
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: got data=%h sop=%b eop=%b with no word expected",
                   ff_tx_data, ff_tx_sop, ff_tx_eop);
        end else begin
          e = q.pop_front();
          if ({ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err, ff_tx_class, ff_tx_end_code}
              !== {e.data, e.sop, e.eop, e.mod, e.err, e.cls, e.ec}) begin
            n_fail++;
            $display("FAIL sb_word: got data=%h sop=%b eop=%b mod=%0d err=%b cls=%h ec=%h, expected data=%h sop=%b eop=%b mod=%0d err=%b cls=%h ec=%h",
                     ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err, ff_tx_class, ff_tx_end_code,
                     e.data, e.sop, e.eop, e.mod, e.err, e.cls, e.ec);
          end
        end
      end
    end
  endtask

  task automatic push_exp(input int tag, input int n, input logic [1:0] lmod, input logic lerr,
                          input logic [3:0] cls);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = pat(tag, i);
      e.sop  = (i == 0);
      e.eop  = (i == n - 1);
      e.mod  = (i == n - 1) ? lmod : 2'd0;
      e.err  = (i == n - 1) ? lerr : 1'b0;
      e.cls  = cls;
      e.ec   = cfg_end_code;
      q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m);
    int k;
    in_data = d; in_sop = s; in_eop = e; in_mod = m; in_valid = 1'b1;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (in_ready) break;
      tick();
    end
    if (k == 2000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=0 for 2000 cycles, required 1");
    end
    tick();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_mod = 2'd0;
  endtask

  task automatic send_frame(input int tag, input int len, input logic [1:0] mod, input int orphans);
    for (int i = 0; i < orphans; i++) send_word(pat(tag, 1000 + i), 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < len; i++)
      send_word(pat(tag, i), (i == 0), (i == len - 1), (i == len - 1) ? mod : 2'd0);
  endtask

  task automatic wait_drain(input string nm);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !ff_tx_wren) break;
    end
    chk(nm, (k < 5000) ? 1 : 0, 1);
    tick();
  endtask

  task automatic wait_xfer(input int target);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (xfer_cnt >= target) break;
    end
    chk("xfer_wait", (k < 200) ? 1 : 0, 1);
  endtask

  initial begin
    int base;
    int gaps[2];
    gaps[0] = 5;
    gaps[1] = 0;
    tbl[0] = '{3,   2'd0, 0, 4'h1, 3,   2'd0, 1'b0, 0,  0};
    tbl[1] = '{1,   2'd1, 3, 4'h2, 1,   2'd1, 1'b0, 3,  0};
    tbl[2] = '{600, 2'd3, 0, 4'h4, 537, 2'd0, 1'b1, 63, 1};
    tbl[3] = '{537, 2'd0, 0, 4'h5, 537, 2'd0, 1'b0, 0,  0};
    tbl[4] = '{538, 2'd1, 0, 4'h6, 537, 2'd0, 1'b1, 1,  1};
    tbl[5] = '{2,   2'd3, 2, 4'h8, 2,   2'd3, 1'b0, 2,  0};

    rst = 1'b1; in_data = '0; in_sop = 0; in_eop = 0; in_mod = 0; in_valid = 0;
    cfg_class = 4'h1; cfg_end_code = 4'hA; cfg_gap = 8'd0; ff_tx_rdy = 1'b1;
    fork monitor(); join_none
    fork begin #3000000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end join_none

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wren", ff_tx_wren, 0);
    chk("rst_stats", stat_frm_sent + stat_frm_trunc + stat_word_drop, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_hold", in_ready, 0);
    tick();
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    tick();

    // 4-word frame: latency and gap-free burst
    base = xfer_cnt;
    push_exp(1, 4, 2'd2, 1'b0, cfg_class);
    send_frame(1, 4, 2'd2, 0);
    wait_drain("t1_drain");
    exp_sent++;
    chk("t1_latency", sop_cyc - eop_acc_cyc, 2);
    chk("t1_burst", eop_xfer_cyc - sop_cyc, 3);
    chk("t1_xfers", xfer_cnt - base, 4);
    chk("t1_sent", stat_frm_sent, exp_sent);

    // Back-pressure for 3 cycles after the 2nd transfer
    base = xfer_cnt;
    push_exp(2, 4, 2'd2, 1'b0, cfg_class);
    send_frame(2, 4, 2'd2, 0);
    wait_xfer(base + 2);
    tick();
    ff_tx_rdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("t2_hold_wren", ff_tx_wren, 1);
      if (q.size() > 0)
        chk("t2_hold_word", {ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_mod},
            {q[0].data, q[0].sop, q[0].eop, q[0].mod});
      else
        chk("t2_queue", q.size(), 1);
      tick();
    end
    ff_tx_rdy = 1'b1;
    wait_drain("t2_drain");
    exp_sent++;
    chk("t2_xfers", xfer_cnt - base, 4);
    chk("t2_sent", stat_frm_sent, exp_sent);

    // Back-to-back frames, class changed during frame 1 egress
    for (int g = 0; g < 2; g++) begin
      cfg_gap = 8'(gaps[g]);
      cfg_class = 4'h3;
      base = xfer_cnt;
      push_exp(10 + g, 2, 2'd1, 1'b0, 4'h3);
      push_exp(20 + g, 2, 2'd3, 1'b0, 4'h7);
      send_frame(10 + g, 2, 2'd1, 0);
      fork
        send_frame(20 + g, 2, 2'd3, 0);
        begin
          wait_xfer(base + 1);
          tick();
          cfg_class = 4'h7;
        end
      join
      wait_drain("t5_drain");
      exp_sent += 2;
      chk("t5_idle_cycles", gap_seen, gaps[g] + 1);
      chk("t5_xfers", xfer_cnt - base, 4);
      chk("t5_sent", stat_frm_sent, exp_sent);
    end
    cfg_gap = 8'd0;

    // Table of frames: orphans, truncation, boundary lengths
    for (int v = 0; v < 6; v++) begin
      cfg_class = tbl[v].cls;
      base = xfer_cnt;
      push_exp(30 + v, tbl[v].exp_out, tbl[v].exp_mod, tbl[v].exp_err, tbl[v].cls);
      send_frame(30 + v, tbl[v].len, tbl[v].mod, tbl[v].orphans);
      wait_drain("tbl_drain");
      exp_sent++;
      exp_trunc += tbl[v].exp_trunc;
      exp_drop  += tbl[v].exp_drop;
      chk("tbl_xfers", xfer_cnt - base, tbl[v].exp_out);
      chk("tbl_sent", stat_frm_sent, exp_sent);
      chk("tbl_trunc", stat_frm_trunc, exp_trunc);
      chk("tbl_drop", stat_word_drop, exp_drop);
    end

    // Reset during SEND word 2 of 8
    base = xfer_cnt;
    cfg_class = 4'h9;
    push_exp(50, 8, 2'd0, 1'b0, cfg_class);
    send_frame(50, 8, 2'd0, 0);
    wait_xfer(base + 1);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_wren", ff_tx_wren, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_sent", stat_frm_sent, 0);
    chk("t6_trunc", stat_frm_trunc, 0);
    chk("t6_drop", stat_word_drop, 0);
    q.delete();
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_rel_in_ready", in_ready, 1);
    base = xfer_cnt;
    repeat (10) tick();
    chk("t6_fifo_empty", xfer_cnt - base, 0);
    push_exp(51, 1, 2'd2, 1'b0, cfg_class);
    send_frame(51, 1, 2'd2, 0);
    wait_drain("t6_drain");
    chk("t6_after_sent", stat_frm_sent, 1);
    chk("t6_after_xfers", xfer_cnt - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_ff_tx_feeder.md
Name: fc_ff_tx_feeder

Overview:
Client-side writer for the MAC transmit FIFO interface (ff_tx_*). It runs in the ff_tx_clk domain and accepts framed 32-bit words from an internal stream. Frames are sanitized (orphan words dropped, oversize frames truncated) and buffered store-and-forward in a local FIFO. Each complete frame is then driven into the MAC with no mid-frame gaps, so the MAC never sees a transmit underflow.

Parameters:
FIFO_ADDR, 10, log2 of local FIFO depth in words (depth 1024).
MAX_WORDS, 537, maximum frame length in 32-bit words (2148-byte FC max frame). Constraint: MAX_WORDS <= 2**FIFO_ADDR.

Ports:
ff_tx_clk  in  1  transmit local clock; all logic on rising edge.
reset_ff_tx_clk  in  1  synchronous reset, active-high.
in_data  in  32  upstream frame word.
in_sop  in  1  first word of frame.
in_eop  in  1  last word of frame.
in_mod  in  2  valid bytes on eop word (0 = all 4, n = n bytes).
in_valid  in  1  upstream word valid.
in_ready  out  1  feeder accepts word; accept = in_valid & in_ready.
cfg_class  in  4  frame class, latched per frame.
cfg_end_code  in  4  frame end code, latched per frame.
cfg_gap  in  8  idle cycles inserted after each frame.
ff_tx_data  out  32  word to MAC.
ff_tx_sop  out  1  start of packet.
ff_tx_eop  out  1  end of packet.
ff_tx_mod  out  2  packet modulo.
ff_tx_err  out  1  packet error (set on truncated frames).
ff_tx_wren  out  1  word valid toward MAC.
ff_tx_class  out  4  latched cfg_class.
ff_tx_end_code  out  4  latched cfg_end_code.
ff_tx_rdy  in  1  MAC FIFO ready; transfer = ff_tx_wren & ff_tx_rdy.
stat_frm_sent  out  32  frames fully transferred, saturating.
stat_frm_trunc  out  16  frames truncated at MAX_WORDS, saturating.
stat_word_drop  out  16  upstream words discarded, saturating.

Behaviour:
- Reset (sync, high): FIFO flushed; all FSMs to idle; all outputs 0, including in_ready.
- Reset (continued): in_ready returns to 1 on the first cycle after reset deasserts, if the FIFO is not full.
- Reset mid-frame: the egress frame is abandoned and ff_tx_wren = 0 on the following cycle. The MAC flags the underflow.
- in_ready = (FIFO count < 2**FIFO_ADDR), registered. Accepted words always consume the input, whether stored or dropped.
- FIFO entry = {data, sop, eop, mod, err}, 37 bits.
- Ingress FSM states: IDLE, FRAME, DISCARD. Word counter wcnt is 1-based and resets on sop.
  - IDLE, accept with in_sop: store the word; go to FRAME, or stay in IDLE if in_eop is also set (single-word frame).
  - IDLE, accept without in_sop: drop the word; stat_word_drop += 1.
  - FRAME: store each word. An in_sop here is cleared and the word is stored as data.
  - FRAME, accept with in_eop: store in_mod; go to IDLE.
  - FRAME, wcnt == MAX_WORDS and in_eop = 0: store the word with eop = 1, err = 1, mod = 0; stat_frm_trunc += 1; go to DISCARD.
  - DISCARD: drop every word (stat_word_drop += 1 each), including sop words. Leave to IDLE after the word carrying in_eop.
- Complete-frame counter fcnt: +1 when an eop entry is written, -1 when an eop word transfers to the MAC. Both in the same cycle leaves fcnt unchanged.
- Egress FSM states: IDLE, SEND, GAP.
  - IDLE: when fcnt > 0, latch cfg_class and cfg_end_code, load the FIFO head into the ff_tx_* registers, go to SEND.
  - SEND: ff_tx_wren = 1. While ff_tx_rdy = 0, all ff_tx_* outputs hold.
  - SEND, on transfer: the next FIFO word loads in the same cycle, so there are no bubbles while ff_tx_rdy stays 1.
  - SEND, on eop transfer: stat_frm_sent += 1; ff_tx_wren = 0 next cycle. Go to GAP if cfg_gap > 0, otherwise IDLE.
  - GAP: count cfg_gap cycles, then go to IDLE.
- Latency, empty FIFO, egress IDLE: eop accepted on edge N gives ff_tx_wren = 1 with the sop word during cycle N+2.
- Back-to-back frames with cfg_gap = 0: exactly 1 idle cycle (the IDLE state) between the eop transfer and the next sop.
- Simultaneous FIFO write and read when full: the read frees an entry, but in_ready is registered, so no write occurs that cycle.
- Counters saturate at all-ones and clear only on reset.

Test Plan:
1. 4-word frame, mod = 2, ff_tx_rdy = 1, cfg_gap = 0 -> sop word out on cycle N+2; 4 consecutive wren cycles; eop word has mod = 2, err = 0; stat_frm_sent = 1.
2. Same frame with ff_tx_rdy low for 3 cycles after the 2nd transfer -> ff_tx_data/sop/eop/mod held constant; frame finishes with 4 transfers total; no duplicate or lost words.
3. 600-word frame without eop until word 600 -> 537 words out, word 537 has eop = 1, err = 1, mod = 0; stat_frm_trunc = 1; stat_word_drop = 63.
4. 3 words without sop, then a 1-word frame (sop = eop = 1) -> stat_word_drop = 3; a single output word with sop = eop = 1.
5. Two 2-word frames back-to-back, cfg_gap = 5, cfg_class = 3 then changed to 7 mid-frame-1 -> 5 GAP cycles plus 1 IDLE cycle between the frames; frame 1 class = 3, frame 2 class = 7.
6. Reset asserted during SEND word 2 of 8 -> ff_tx_wren = 0 the next cycle; FIFO empty; all stats 0; in_ready = 1 one cycle after release.
